// File: rtl/response_uart_tx.sv
// response_uart_tx: queues decoder {code, value} pairs and sends each
// pair as two back-to-back 8N1 UART frames, code byte first.
module response_uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       finished,
  input  logic [7:0] response_code,
  input  logic [7:0] response,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic          finished_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   hold_q, hold_d;
  logic          byte_sel_q, byte_sel_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [BW-1:0] baud_q, baud_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;

  logic [15:0]   mem [FIFO_DEPTH];

  logic          push, pop, wr_en;
  logic          full, empty, baud_end;
  logic [7:0]    cur_byte;

  always_comb begin
    push     = finished & ~finished_q;
    full     = (count_q == DEPTH_C);
    empty    = (count_q == '0);
    baud_end = (baud_q == BAUD_MAX);
    cur_byte = byte_sel_q ? hold_q[7:0] : hold_q[15:8];

    state_d    = state_q;
    byte_sel_d = byte_sel_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    tx_d       = tx_q;
    pop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          state_d    = START;
          byte_sel_d = 1'b0;
          baud_d     = '0;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
          baud_d    = '0;
          tx_d      = cur_byte[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            state_d    = START;
            tx_d       = 1'b0;
          end else if (!empty) begin
            // chain the next pair straight off this stop bit
            pop        = 1'b1;
            byte_sel_d = 1'b0;
            state_d    = START;
            tx_d       = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    hold_d = pop ? mem[rd_ptr_q] : hold_q;

    // a full FIFO still takes a push when a pop frees the slot
    wr_en = push & (~full | pop);
    ovf_d = push & full & ~pop;

    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    unique case (1'b1)
      (wr_en & ~pop): count_d = count_q + CW'(1);
      (pop & ~wr_en): count_d = count_q - CW'(1);
      default:        count_d = count_q;
    endcase

    busy_d = (state_d != IDLE) | (count_d != '0);
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= {response_code, response};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      finished_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_q     <= '0;
      byte_sel_q <= 1'b0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      finished_q <= finished;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      byte_sel_q <= byte_sel_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_response_uart_tx.sv
// tb_response_uart_tx: directed checks of capture, framing, back-to-back
// chaining, overflow, push/pop at full and mid-frame reset.
module tb_response_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       finished = 1'b0;
  logic [7:0] response_code = 8'h00;
  logic [7:0] response = 8'h00;
  logic       tx, busy, overflow;

  int tests = 0;
  int fails = 0;
  int ovf_cnt = 0;
  int busy_drop = 0;
  bit mon_busy = 1'b0;

  response_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .finished     (finished),
    .response_code(response_code),
    .response     (response),
    .tx           (tx),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (overflow === 1'b1) ovf_cnt++;
    if (mon_busy && busy !== 1'b1) busy_drop++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the last negedge of the stop bit.
  task automatic rx_byte(input string tag,
                         output logic [7:0] b,
                         output int waited);
    int n;
    b = 8'h00;
    n = 0;
    waited = 0;
    while (n < 400) begin
      @(negedge clock);
      if (tx === 1'b0) break;
      n++;
    end
    waited = n;
    if (n >= 400) begin
      tests++;
      fails++;
      $error("FAIL %s_timeout: got no start bit expected one", tag);
      return;
    end
    repeat (5) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      b[i] = tx;
      repeat (4) @(negedge clock);
    end
    chk({tag, "_stop"}, 32'(tx), 1);
    repeat (2) @(negedge clock);
  endtask

  task automatic rx_pair(input string tag,
                         input logic [7:0] c,
                         input logic [7:0] v,
                         input int w0);
    logic [7:0] b;
    int w;
    rx_byte({tag, "_c"}, b, w);
    chk({tag, "_code"}, 32'(b), 32'(c));
    chk({tag, "_gap0"}, 32'(w), 32'(w0));
    rx_byte({tag, "_v"}, b, w);
    chk({tag, "_val"}, 32'(b), 32'(v));
    chk({tag, "_gap1"}, 32'(w), 0);
  endtask

  task automatic pulse(input logic [7:0] c, input logic [7:0] v);
    response_code = c;
    response = v;
    finished = 1'b1;
    @(negedge clock);
    finished = 1'b0;
  endtask

  initial begin
    int ov0;
    int lows;

    repeat (3) @(negedge clock);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // single pair
    pulse(8'h13, 8'h19);
    chk("single_tx_pre", 32'(tx), 1);
    chk("single_busy_rise", 32'(busy), 1);
    rx_pair("single", 8'h13, 8'h19, 0);
    chk("single_busy_end", 32'(busy), 1);
    @(negedge clock);
    chk("single_busy_fall", 32'(busy), 0);
    chk("single_tx_idle", 32'(tx), 1);

    // held strobe
    ov0 = ovf_cnt;
    fork
      begin
        response_code = 8'h10;
        response = 8'h11;
        finished = 1'b1;
        repeat (10) @(negedge clock);
        finished = 1'b0;
      end
      rx_pair("held", 8'h10, 8'h11, 1);
    join
    lows = 0;
    repeat (60) begin
      @(negedge clock);
      if (tx !== 1'b1) lows++;
    end
    chk("held_one_pair", 32'(lows), 0);
    chk("held_busy", 32'(busy), 0);
    chk("held_no_ovf", 32'(ovf_cnt - ov0), 0);

    // back-to-back
    fork
      begin
        pulse(8'h13, 8'h01);
        repeat (4) @(negedge clock);
        pulse(8'h14, 8'h02);
        repeat (4) @(negedge clock);
        pulse(8'h15, 8'hCA);
      end
      begin
        rx_pair("b2b0", 8'h13, 8'h01, 1);
        rx_pair("b2b1", 8'h14, 8'h02, 0);
        rx_pair("b2b2", 8'h15, 8'hCA, 0);
      end
    join
    chk("b2b_busy_end", 32'(busy), 1);
    @(negedge clock);
    chk("b2b_busy_fall", 32'(busy), 0);

    // overflow
    ov0 = ovf_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          pulse(8'(8'hA0 + i), 8'(i));
          chk("ovf_pulse", 32'(overflow), 32'(i == 5));
          @(negedge clock);
        end
        chk("ovf_one_cycle", 32'(overflow), 0);
      end
      begin
        @(negedge clock);
        mon_busy = 1'b1;
        for (int i = 0; i < 5; i++)
          rx_pair("ovf", 8'(8'hA0 + i), 8'(i), 0);
        mon_busy = 1'b0;
      end
    join
    chk("ovf_busy_held", 32'(busy_drop), 0);
    chk("ovf_count", 32'(ovf_cnt - ov0), 1);
    @(negedge clock);
    chk("ovf_busy_fall", 32'(busy), 0);
    chk("ovf_tx_idle", 32'(tx), 1);

    // push aligned with pop while full
    ov0 = ovf_cnt;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          pulse(8'(8'hB0 + i), 8'(8'h10 + i));
          @(negedge clock);
        end
      end
      begin
        rx_pair("pp0", 8'hB0, 8'h10, 1);
        response_code = 8'hEE;
        response = 8'h77;
        finished = 1'b1;
        fork
          begin
            @(negedge clock);
            finished = 1'b0;
          end
        join_none
        for (int i = 1; i < 5; i++)
          rx_pair("pp", 8'(8'hB0 + i), 8'(8'h10 + i), 0);
        rx_pair("pp_last", 8'hEE, 8'h77, 0);
      end
    join
    chk("pp_no_ovf", 32'(ovf_cnt - ov0), 0);
    @(negedge clock);
    chk("pp_busy_fall", 32'(busy), 0);

    // reset during data bit 3 of the code byte
    pulse(8'h13, 8'h55);
    @(negedge clock);
    chk("rst_mid_start", 32'(tx), 0);
    repeat (17) @(negedge clock);
    chk("rst_mid_bit3", 32'(tx), 0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_tx", 32'(tx), 1);
    chk("rst_mid_busy", 32'(busy), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    lows = 0;
    repeat (100) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("rst_idle_after", 32'(lows), 0);
    pulse(8'h21, 8'h42);
    rx_pair("post_rst", 8'h21, 8'h42, 0);
    @(negedge clock);
    chk("post_rst_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/response_uart_tx.md
# response_uart_tx

Downstream stage of the sensor decoder. Captures each `{response_code, response}` pair presented with the decoder's one-cycle `finished` strobe and queues it in a small FIFO. Serialises every pair onto a UART line as two 8N1 frames: code byte first, then value byte. Sits between the decoder and the board's TX pin, so decoder results are never lost while a previous answer is still on the wire.

## Interface
- `CLKS_PER_BIT`, 5208, clock cycles per UART bit (50 MHz / 9600 baud); must be ≥ 2.
- `FIFO_DEPTH`, 4, number of pairs buffered; power of two, ≥ 2.

- `clock`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `finished`  in  1  decoder completion strobe; a pair is captured on its rising edge.
- `response_code`  in  8  code byte, sampled with `finished`.
- `response`  in  8  value byte, sampled with `finished`.
- `tx`  out  1  UART serial output, idle high.
- `busy`  out  1  high while the FIFO is non-empty or a frame is in progress.
- `overflow`  out  1  one-cycle pulse when a pair is dropped because the FIFO is full.

## Operation
- **Edge detect:** `push = finished & ~finished_q`.
  - `finished_q` is a register, reset to 0.
  - Holding `finished` high pushes only once.
- **FIFO:** 16-bit entries `{response_code, response}`.
  - Read/write pointers wrap modulo `FIFO_DEPTH`.
  - Count width is `clog2(FIFO_DEPTH)+1`.
- **Push when full:**
  - With no pop in the same cycle, the pair is dropped and `overflow` pulses.
  - With a pop in the same cycle, the push is accepted and the count is unchanged.
- **Push and pop in the same cycle, not full:** both take effect; count unchanged.
- **TX state machine:** `IDLE`, `START`, `DATA`, `STOP`.
  - `byte_sel` selects code (0) or value (1).
  - `bit_idx` counts 0..7.
  - `baud_cnt` counts 0..`CLKS_PER_BIT`-1.
- **`IDLE`:** `tx`=1. If the FIFO is non-empty: pop into a 16-bit shift holding register, set `byte_sel`=0, go to `START`.
- **`START`:** `tx`=0 for `CLKS_PER_BIT` cycles, then go to `DATA` with `bit_idx`=0.
- **`DATA`:** `tx` = current byte bit `bit_idx`, LSB first, for `CLKS_PER_BIT` cycles each. After bit 7, go to `STOP`.
- **`STOP`:** `tx`=1 for `CLKS_PER_BIT` cycles, then:
  - if `byte_sel`=0: set `byte_sel`=1 and go to `START`;
  - else, if the FIFO is non-empty: pop, set `byte_sel`=0, go to `START`, with no idle gap;
  - else go to `IDLE`.
- **Outputs:** `tx` is driven from a register, never from combinational logic.
- **`busy`** = (state ≠ `IDLE`) | (count ≠ 0).
- **Reset values:** `tx`=1, `busy`=0, `overflow`=0, state=`IDLE`, FIFO empty, all counters 0.
- **Reset mid-frame:** the line returns high immediately (async). Queued and in-flight pairs are discarded. No partial frame resumes after release.
- **Unused entries:** FIFO contents are not reset; only the pointers and count are.

## Timing
- **Capture:** `finished` rises, sampled at edge N; the entry is written and the count incremented at edge N.
- **First start bit:** with the FIFO empty and the FSM in `IDLE`, the pop occurs at edge N+1 and `tx` goes low at edge N+1.
- **First-bit latency:** 1 cycle after capture.
- **Frame length:** 10·`CLKS_PER_BIT` cycles.
- **Pair length:** 20·`CLKS_PER_BIT` cycles, from the start-bit falling edge to the end of the second stop bit.
- **Back-to-back pairs:** the next start bit begins on the edge that ends the previous stop bit; zero idle cycles.
- **`busy`:**
  - Rises at edge N (count becomes non-zero).
  - Falls on the edge where the final stop bit ends with the FIFO empty.
- **`overflow`:** asserted for exactly the one cycle following the dropping edge.
- **Throughput:** one pair per 20·`CLKS_PER_BIT` cycles. Sustained decoder rate above that overflows after `FIFO_DEPTH` + 1 outstanding pairs (the in-flight pair plus a full FIFO).

## Test plan
Benches use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- **Single pair:** pulse `finished` 1 cycle with code 0x13, value 0x19 → `tx` low 1 cycle later. Serial decode yields 0x13 then 0x19, each frame exactly 40 cycles. `busy` falls after 80 cycles of line activity.
- **Held strobe:** hold `finished` high 10 cycles with 0x10/0x11 → exactly one pair transmitted. `overflow` never asserts.
- **Back-to-back:** 3 pulses 5 cycles apart with 0x13/0x01, 0x14/0x02, 0x15/0xCA → six bytes in order with no idle cycles between frames. Total line activity 240 cycles.
- **Overflow:** 6 pulses 2 cycles apart with values 0..5 → pairs 0–4 transmitted. `overflow` pulses once, for pair 5. `busy` stays high throughout.
- **Simultaneous push/pop at full:** with the FIFO full, align a push with the pop at the end of the in-flight pair's final stop bit → pair accepted, no `overflow`, transmitted last.
- **Reset mid-frame:** assert `reset_n` low during `DATA` bit 3 of a code byte → `tx`=1 and `busy`=0 immediately. After release, the line stays idle until the next `finished`.
